// File: rtl/gumnut_fetch_decode.sv
// Gumnut fetch/decode: fetches into a one-entry IR, one instruction per 2 cycles at zero wait states.
// Backpressure: IR holds (bus idle) while ir_ready_i is low; redirect flushes the IR and aborts any bus cycle.
module gumnut_fetch_decode #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        inst_cyc_o,
  output logic        inst_stb_o,
  input  logic        inst_ack_i,
  output logic [11:0] inst_adr_o,
  input  logic [17:0] inst_dat_i,
  output logic        ir_valid_o,
  input  logic        ir_ready_i,
  input  logic        redirect_i,
  input  logic [11:0] redirect_adr_i,
  output logic [17:0] ir_o,
  output logic [11:0] ir_pc_o,
  output logic        dec_alu_immed_o,
  output logic        dec_mem_o,
  output logic        dec_shift_o,
  output logic        dec_alu_reg_o,
  output logic        dec_jump_o,
  output logic        dec_branch_o,
  output logic        dec_misc_o,
  output logic        dec_illegal_o,
  output logic [2:0]  fn_o,
  output logic [2:0]  rd_o,
  output logic [2:0]  rs_o,
  output logic [2:0]  r2_o,
  output logic [7:0]  immed_o,
  output logic [11:0] addr_o
);

  typedef enum logic [1:0] {IDLE, FETCH, FULL} state_e;

  typedef struct packed {
    logic alu_immed;
    logic mem;
    logic shift;
    logic alu_reg;
    logic jump;
    logic branch;
    logic misc;
    logic illegal;
  } dec_t;

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [17:0] ir_q, ir_d;
  logic [11:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic        bubble_q, bubble_d;
  logic        fetch_active;
  dec_t        dec;
  logic [2:0]  fn;

  // After a redirect the bus stays idle for one cycle before restarting at the new PC.
  assign fetch_active = (state_q == FETCH) && !bubble_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    bubble_d   = 1'b0;
    if (redirect_i) begin
      pc_d       = redirect_adr_i;
      ir_valid_d = 1'b0;
      state_d    = FETCH;
      bubble_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE:  state_d = FETCH;
        FETCH: begin
          if (fetch_active && inst_ack_i) begin
            ir_d       = inst_dat_i;
            ir_pc_d    = pc_q;
            pc_d       = pc_q + 12'd1;
            ir_valid_d = 1'b1;
            state_d    = FULL;
          end
        end
        FULL: begin
          if (ir_ready_i) begin
            ir_valid_d = 1'b0;
            state_d    = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      bubble_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      bubble_q   <= bubble_d;
    end
  end

  // Opcode classes are prefix codes: the first zero bit from the top selects the class.
  always_comb begin
    dec = '0;
    fn  = 3'd0;
    if (!ir_q[17]) begin
      dec.alu_immed = 1'b1;
      fn            = ir_q[16:14];
    end else if (!ir_q[16]) begin
      dec.mem = 1'b1;
      fn      = {1'b0, ir_q[15:14]};
    end else if (!ir_q[15]) begin
      dec.shift = 1'b1;
      fn        = ir_q[2:0];
    end else if (!ir_q[14]) begin
      dec.alu_reg = 1'b1;
      fn          = ir_q[2:0];
    end else if (!ir_q[13]) begin
      dec.jump = 1'b1;
      fn       = {2'b00, ir_q[12]};
    end else if (!ir_q[12]) begin
      dec.branch = 1'b1;
      fn         = {1'b0, ir_q[11:10]};
    end else if (!ir_q[11]) begin
      dec.misc = 1'b1;
      fn       = ir_q[10:8];
    end else begin
      dec.illegal = 1'b1;
    end
    if (!ir_valid_q) begin
      dec = '0;
    end
  end

  assign inst_cyc_o      = fetch_active;
  assign inst_stb_o      = fetch_active;
  assign inst_adr_o      = pc_q;
  assign ir_valid_o      = ir_valid_q;
  assign ir_o            = ir_q;
  assign ir_pc_o         = ir_pc_q;
  assign dec_alu_immed_o = dec.alu_immed;
  assign dec_mem_o       = dec.mem;
  assign dec_shift_o     = dec.shift;
  assign dec_alu_reg_o   = dec.alu_reg;
  assign dec_jump_o      = dec.jump;
  assign dec_branch_o    = dec.branch;
  assign dec_misc_o      = dec.misc;
  assign dec_illegal_o   = dec.illegal;
  assign fn_o            = fn;
  assign rd_o            = ir_q[13:11];
  assign rs_o            = ir_q[10:8];
  assign r2_o            = ir_q[7:5];
  assign immed_o         = ir_q[7:0];
  assign addr_o          = ir_q[11:0];

endmodule

// File: tb/tb_gumnut_fetch_decode.sv
// Directed bench for gumnut_fetch_decode with a wait-state-configurable instruction memory responder.
module tb_gumnut_fetch_decode;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        inst_cyc_o, inst_stb_o, inst_ack_i;
  logic [11:0] inst_adr_o;
  logic [17:0] inst_dat_i;
  logic        ir_valid_o, ir_ready_i, redirect_i;
  logic [11:0] redirect_adr_i;
  logic [17:0] ir_o;
  logic [11:0] ir_pc_o;
  logic        dec_alu_immed_o, dec_mem_o, dec_shift_o, dec_alu_reg_o;
  logic        dec_jump_o, dec_branch_o, dec_misc_o, dec_illegal_o;
  logic [2:0]  fn_o, rd_o, rs_o, r2_o;
  logic [7:0]  immed_o;
  logic [11:0] addr_o;
  logic [7:0]  dec_vec;

  int checks = 0;
  int errors = 0;

  logic [17:0] mem [4096];
  logic [17:0] xor_pat = '0;
  int          wait_states = 0;

  // Decode table: raw instruction and expected class/fields.
  logic [17:0] dv_ir   [8] = '{18'h05A5F, 18'h38101, 18'h3F300, 18'h3FE00, 18'h3D123, 18'h3EC05, 18'h24000, 18'h300E5};
  logic [7:0]  dv_dec  [8] = '{8'h80, 8'h10, 8'h02, 8'h01, 8'h08, 8'h04, 8'h40, 8'h20};
  logic [2:0]  dv_fn   [8] = '{3'd1, 3'd1, 3'd3, 3'd0, 3'd1, 3'd3, 3'd1, 3'd5};
  logic [2:0]  dv_rd   [8] = '{3'd3, 3'd0, 3'd6, 3'd7, 3'd2, 3'd5, 3'd0, 3'd0};
  logic [2:0]  dv_rs   [8] = '{3'd2, 3'd1, 3'd3, 3'd6, 3'd1, 3'd4, 3'd0, 3'd0};
  logic [2:0]  dv_r2   [8] = '{3'd2, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd7};
  logic [7:0]  dv_imm  [8] = '{8'h5F, 8'h01, 8'h00, 8'h00, 8'h23, 8'h05, 8'h00, 8'hE5};
  logic [11:0] dv_addr [8] = '{12'hA5F, 12'h101, 12'h300, 12'hE00, 12'h123, 12'hC05, 12'h000, 12'h0E5};

  assign dec_vec = {dec_alu_immed_o, dec_mem_o, dec_shift_o, dec_alu_reg_o,
                    dec_jump_o, dec_branch_o, dec_misc_o, dec_illegal_o};

  gumnut_fetch_decode #(.RESET_PC(12'h000)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .inst_cyc_o(inst_cyc_o), .inst_stb_o(inst_stb_o), .inst_ack_i(inst_ack_i),
    .inst_adr_o(inst_adr_o), .inst_dat_i(inst_dat_i),
    .ir_valid_o(ir_valid_o), .ir_ready_i(ir_ready_i),
    .redirect_i(redirect_i), .redirect_adr_i(redirect_adr_i),
    .ir_o(ir_o), .ir_pc_o(ir_pc_o),
    .dec_alu_immed_o(dec_alu_immed_o), .dec_mem_o(dec_mem_o), .dec_shift_o(dec_shift_o),
    .dec_alu_reg_o(dec_alu_reg_o), .dec_jump_o(dec_jump_o), .dec_branch_o(dec_branch_o),
    .dec_misc_o(dec_misc_o), .dec_illegal_o(dec_illegal_o),
    .fn_o(fn_o), .rd_o(rd_o), .rs_o(rs_o), .r2_o(r2_o), .immed_o(immed_o), .addr_o(addr_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory responder: acks after wait_states idle cycles of an active bus cycle.
  initial begin : responder
    int wcnt;
    wcnt       = 0;
    inst_ack_i = 1'b0;
    inst_dat_i = '0;
    forever begin
      @(negedge clk_i);
      if (inst_cyc_o) begin
        if (wcnt >= wait_states) begin
          inst_ack_i = 1'b1;
          inst_dat_i = mem[inst_adr_o] ^ xor_pat;
          wcnt       = 0;
        end else begin
          inst_ack_i = 1'b0;
          inst_dat_i = '0;
          wcnt++;
        end
      end else begin
        inst_ack_i = 1'b0;
        inst_dat_i = '0;
        wcnt       = 0;
      end
    end
  end

  // Leaves the bench at the first negedge in FETCH (cyc high at RESET_PC).
  task automatic reset_dut();
    rst_i          = 1'b0;
    redirect_i     = 1'b0;
    redirect_adr_i = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    #1 rst_i = 1'b0;
    #1;
    checks++;
    if ({inst_cyc_o, inst_stb_o, ir_valid_o, inst_adr_o, ir_o, ir_pc_o, dec_vec} !== {3'b000, 12'h000, 18'h0, 12'h000, 8'h00}) begin
      errors++;
      $display("FAIL reset_async: got cyc=%b stb=%b vld=%b adr=%h ir=%h pc=%h dec=%b, want 0 0 0 000 00000 000 00000000",
               inst_cyc_o, inst_stb_o, ir_valid_o, inst_adr_o, ir_o, ir_pc_o, dec_vec);
    end
    @(negedge clk_i);
    checks++;
    if ({inst_cyc_o, ir_valid_o, inst_adr_o, dec_vec} !== {2'b00, 12'h000, 8'h00}) begin
      errors++;
      $display("FAIL reset_held: got cyc=%b vld=%b adr=%h dec=%b, want 0 0 000 00000000", inst_cyc_o, ir_valid_o, inst_adr_o, dec_vec);
    end
  endtask

  task automatic test_zero_wait();
    wait_states = 0; xor_pat = '0; ir_ready_i = 1'b1;
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({inst_cyc_o, inst_stb_o, ir_valid_o, inst_adr_o} !== {3'b110, 12'(i)}) begin
        errors++;
        $display("FAIL zw_fetch%0d: got cyc=%b stb=%b vld=%b adr=%h, want 1 1 0 %h", i, inst_cyc_o, inst_stb_o, ir_valid_o, inst_adr_o, 12'(i));
      end
      @(negedge clk_i);
      checks++;
      if ({ir_valid_o, inst_cyc_o, ir_o, ir_pc_o} !== {2'b10, 18'(i), 12'(i)}) begin
        errors++;
        $display("FAIL zw_full%0d: got vld=%b cyc=%b ir=%h pc=%h, want 1 0 %h %h", i, ir_valid_o, inst_cyc_o, ir_o, ir_pc_o, 18'(i), 12'(i));
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_wait_states();
    wait_states = 3; xor_pat = 18'h25A00; ir_ready_i = 1'b0;
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({inst_cyc_o, inst_stb_o, ir_valid_o, inst_adr_o} !== {3'b110, 12'h000}) begin
        errors++;
        $display("FAIL ws_hold%0d: got cyc=%b stb=%b vld=%b adr=%h, want 1 1 0 000", k, inst_cyc_o, inst_stb_o, ir_valid_o, inst_adr_o);
      end
      @(negedge clk_i);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({ir_valid_o, inst_cyc_o, ir_o, ir_pc_o, dec_vec, fn_o} !== {2'b10, 18'h25A00, 12'h000, 8'h40, 3'd1}) begin
        errors++;
        $display("FAIL ws_stable%0d: got vld=%b cyc=%b ir=%h pc=%h dec=%b fn=%0d, want 1 0 25a00 000 01000000 1",
                 k, ir_valid_o, inst_cyc_o, ir_o, ir_pc_o, dec_vec, fn_o);
      end
      @(negedge clk_i);
    end
    ir_ready_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({inst_cyc_o, ir_valid_o, inst_adr_o} !== {2'b10, 12'h001}) begin
      errors++;
      $display("FAIL ws_next_fetch: got cyc=%b vld=%b adr=%h, want 1 0 001", inst_cyc_o, ir_valid_o, inst_adr_o);
    end
  endtask

  task automatic test_redirect();
    wait_states = 0; xor_pat = '0; ir_ready_i = 1'b1;
    reset_dut();
    redirect_i = 1'b1; redirect_adr_i = 12'h123;
    @(negedge clk_i);
    redirect_i = 1'b0;
    checks++;
    if ({inst_cyc_o, inst_stb_o, ir_valid_o, ir_o} !== {3'b000, 18'h0}) begin
      errors++;
      $display("FAIL rd_bubble: got cyc=%b stb=%b vld=%b ir=%h, want 0 0 0 00000", inst_cyc_o, inst_stb_o, ir_valid_o, ir_o);
    end
    @(negedge clk_i);
    checks++;
    if ({inst_cyc_o, inst_stb_o, ir_valid_o, inst_adr_o} !== {3'b110, 12'h123}) begin
      errors++;
      $display("FAIL rd_refetch: got cyc=%b stb=%b vld=%b adr=%h, want 1 1 0 123", inst_cyc_o, inst_stb_o, ir_valid_o, inst_adr_o);
    end
    @(negedge clk_i);
    checks++;
    if ({ir_valid_o, ir_o, ir_pc_o} !== {1'b1, 18'h00123, 12'h123}) begin
      errors++;
      $display("FAIL rd_data: got vld=%b ir=%h pc=%h, want 1 00123 123", ir_valid_o, ir_o, ir_pc_o);
    end
  endtask

  task automatic test_wrap();
    wait_states = 0; xor_pat = '0; ir_ready_i = 1'b1;
    reset_dut();
    redirect_i = 1'b1; redirect_adr_i = 12'hFFF;
    @(negedge clk_i);
    redirect_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({ir_valid_o, ir_o, ir_pc_o} !== {1'b1, 18'h00FFF, 12'hFFF}) begin
      errors++;
      $display("FAIL wrap_last: got vld=%b ir=%h pc=%h, want 1 00fff fff", ir_valid_o, ir_o, ir_pc_o);
    end
    @(negedge clk_i);
    checks++;
    if ({inst_cyc_o, inst_adr_o} !== {1'b1, 12'h000}) begin
      errors++;
      $display("FAIL wrap_adr: got cyc=%b adr=%h, want 1 000", inst_cyc_o, inst_adr_o);
    end
    @(negedge clk_i);
    checks++;
    if ({ir_valid_o, ir_o, ir_pc_o} !== {1'b1, 18'h0, 12'h000}) begin
      errors++;
      $display("FAIL wrap_next: got vld=%b ir=%h pc=%h, want 1 00000 000", ir_valid_o, ir_o, ir_pc_o);
    end
  endtask

  task automatic test_decode();
    wait_states = 0; xor_pat = '0; ir_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) mem[12'h200 + i] = dv_ir[i];
    reset_dut();
    redirect_i = 1'b1; redirect_adr_i = 12'h200;
    @(negedge clk_i);
    redirect_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({ir_valid_o, dec_vec} !== 9'h000) begin
      errors++;
      $display("FAIL dec_gated: got vld=%b dec=%b, want 0 00000000", ir_valid_o, dec_vec);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      checks++;
      if ({ir_valid_o, ir_o, dec_vec, fn_o, rd_o, rs_o, r2_o, immed_o, addr_o} !==
          {1'b1, dv_ir[i], dv_dec[i], dv_fn[i], dv_rd[i], dv_rs[i], dv_r2[i], dv_imm[i], dv_addr[i]}) begin
        errors++;
        $display("FAIL dec%0d: got vld=%b ir=%h dec=%b fn=%0d rd=%0d rs=%0d r2=%0d imm=%h addr=%h, want 1 %h %b %0d %0d %0d %0d %h %h",
                 i, ir_valid_o, ir_o, dec_vec, fn_o, rd_o, rs_o, r2_o, immed_o, addr_o,
                 dv_ir[i], dv_dec[i], dv_fn[i], dv_rd[i], dv_rs[i], dv_r2[i], dv_imm[i], dv_addr[i]);
      end
      checks++;
      if ($countones(dec_vec) != 1) begin
        errors++;
        $display("FAIL dec_onehot%0d: got %0d classes high (dec=%b), want 1", i, $countones(dec_vec), dec_vec);
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset_mid();
    wait_states = 0; xor_pat = '0; ir_ready_i = 1'b0;
    reset_dut();
    @(negedge clk_i);
    checks++;
    if ({ir_valid_o, dec_vec} !== {1'b1, 8'h80}) begin
      errors++;
      $display("FAIL rm_pre_full: got vld=%b dec=%b, want 1 10000000", ir_valid_o, dec_vec);
    end
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if ({ir_valid_o, inst_cyc_o, dec_vec, ir_o} !== {2'b00, 8'h00, 18'h0}) begin
      errors++;
      $display("FAIL rm_full_drop: got vld=%b cyc=%b dec=%b ir=%h, want 0 0 00000000 00000", ir_valid_o, inst_cyc_o, dec_vec, ir_o);
    end
    wait_states = 3; ir_ready_i = 1'b1;
    reset_dut();
    redirect_i = 1'b1; redirect_adr_i = 12'h055;
    @(negedge clk_i);
    redirect_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({inst_cyc_o, inst_adr_o} !== {1'b1, 12'h055}) begin
      errors++;
      $display("FAIL rm_pre_wait: got cyc=%b adr=%h, want 1 055", inst_cyc_o, inst_adr_o);
    end
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if ({inst_cyc_o, inst_stb_o, ir_valid_o, dec_vec, inst_adr_o} !== {3'b000, 8'h00, 12'h000}) begin
      errors++;
      $display("FAIL rm_wait_drop: got cyc=%b stb=%b vld=%b dec=%b adr=%h, want 0 0 0 00000000 000",
               inst_cyc_o, inst_stb_o, ir_valid_o, dec_vec, inst_adr_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({inst_cyc_o, inst_adr_o} !== {1'b1, 12'h000}) begin
      errors++;
      $display("FAIL rm_restart: got cyc=%b adr=%h, want 1 000", inst_cyc_o, inst_adr_o);
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 18'(a);
    ir_ready_i     = 1'b0;
    redirect_i     = 1'b0;
    redirect_adr_i = '0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_redirect();
    test_wrap();
    test_decode();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
